// File: rtl/idli_pkg.sv
// Shared core types: slot counter, nibble slice, and memory-arbiter enums.
package idli_pkg;

  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_ADDR,
    MA_DATA
  } ma_state_t;

  typedef enum logic {
    MA_SRC_FE = 1'b0,
    MA_SRC_EX = 1'b1
  } ma_src_t;

endpackage

// File: rtl/idli_mem_arb_m_if.sv
// Nibble-serial memory port: select, direction, and split write/read slice lanes.
interface idli_mem_arb_m_if;
  import idli_pkg::*;

  logic   cs;
  logic   we;
  logic   oe;
  slice_t sio;
  slice_t sio_rd;

  modport master (output cs, output we, output oe, output sio, input sio_rd);
  modport slave  (input cs, input we, input oe, input sio, output sio_rd);
endinterface

// File: rtl/idli_rr_arb_m.sv
// Two-way round-robin arbiter; bit 0 is fetch, bit 1 is execute.
module idli_rr_arb_m
  import idli_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  ma_src_t last_q;

  // On conflict the side not granted last time wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_q == MA_SRC_FE) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= MA_SRC_FE;
    end else if (upd && (|gnt)) begin
      last_q <= gnt[1] ? MA_SRC_EX : MA_SRC_FE;
    end
  end

endmodule

// File: rtl/idli_mem_arb_m.sv
// Slot-aligned arbiter/sequencer for the shared nibble-serial memory port.
// Owns the core-wide slot counter; each transaction is one address slot plus one data slot.
module idli_mem_arb_m
  import idli_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic             i_ma_gck,
  input  logic             i_ma_rst,
  output logic [CTR_W-1:0] o_ma_ctr,

  input  logic             i_ma_fe_req,
  input  slice_t           i_ma_fe_addr,
  output logic             o_ma_fe_gnt,
  output logic             o_ma_fe_vld,

  input  logic             i_ma_ex_req,
  input  logic             i_ma_ex_wr,
  input  slice_t           i_ma_ex_addr,
  input  slice_t           i_ma_ex_wdata,
  output logic             o_ma_ex_gnt,
  output logic             o_ma_ex_vld,

  output slice_t           o_ma_rdata,
  output logic             o_ma_busy,

  idli_mem_arb_m_if.master mem
);

  logic [CTR_W-1:0] ctr_q;
  ma_state_t        state_q;
  ma_state_t        state_d;
  ma_src_t          owner_q;
  logic             we_q;
  logic             slot_end;
  logic             decide;
  logic [1:0]       req;
  logic [1:0]       gnt;

  assign slot_end = &ctr_q;
  // A new owner may be chosen at the end of an idle slot or at the end of a data slot.
  assign decide   = slot_end && (state_q != MA_ADDR);
  assign req      = {i_ma_ex_req, i_ma_fe_req};
  assign o_ma_ctr = ctr_q;

  idli_rr_arb_m u_arb (
    .clk (i_ma_gck),
    .rst (i_ma_rst),
    .req (req),
    .upd (decide),
    .gnt (gnt)
  );

  always_ff @(posedge i_ma_gck) begin
    if (i_ma_rst) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_q + CTR_W'(1);
    end
  end

  always_ff @(posedge i_ma_gck) begin
    if (i_ma_rst) begin
      state_q <= MA_IDLE;
      owner_q <= MA_SRC_FE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (decide && (|gnt)) begin
        owner_q <= gnt[1] ? MA_SRC_EX : MA_SRC_FE;
        we_q    <= gnt[1] & i_ma_ex_wr;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      case (state_q)
        MA_ADDR: state_d = MA_DATA;
        default: state_d = (|req) ? MA_ADDR : MA_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ma_fe_gnt = decide & gnt[0];
    o_ma_ex_gnt = decide & gnt[1];
    o_ma_busy   = (state_q != MA_IDLE);
    mem.cs      = (state_q != MA_IDLE);
    mem.we      = (state_q != MA_IDLE) & we_q;
    mem.oe      = 1'b0;
    mem.sio     = '0;
    o_ma_fe_vld = 1'b0;
    o_ma_ex_vld = 1'b0;
    case (state_q)
      MA_ADDR: begin
        mem.oe  = 1'b1;
        mem.sio = (owner_q == MA_SRC_EX) ? i_ma_ex_addr : i_ma_fe_addr;
      end
      MA_DATA: begin
        if (we_q) begin
          mem.oe  = 1'b1;
          mem.sio = i_ma_ex_wdata;
        end else begin
          o_ma_fe_vld = (owner_q == MA_SRC_FE);
          o_ma_ex_vld = (owner_q == MA_SRC_EX);
        end
      end
      default: ;
    endcase
  end

  assign o_ma_rdata = mem.sio_rd;

endmodule

// File: tb/tb_idli_mem_arb_m.sv
// Directed bench for idli_mem_arb_m: idle slots, fetch load, execute store, conflicts, reset.
module tb_idli_mem_arb_m;
  import idli_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  ctr_t   ctr;
  logic   fe_req, fe_gnt, fe_vld;
  slice_t fe_addr;
  logic   ex_req, ex_wr, ex_gnt, ex_vld;
  slice_t ex_addr, ex_wdata;
  slice_t rdata;
  logic   busy;

  int n_run  = 0;
  int n_fail = 0;
  int cyc    = 0;

  idli_mem_arb_m_if mem_if ();

  idli_mem_arb_m #(.CTR_W(2)) dut (
    .i_ma_gck      (clk),
    .i_ma_rst      (rst),
    .o_ma_ctr      (ctr),
    .i_ma_fe_req   (fe_req),
    .i_ma_fe_addr  (fe_addr),
    .o_ma_fe_gnt   (fe_gnt),
    .o_ma_fe_vld   (fe_vld),
    .i_ma_ex_req   (ex_req),
    .i_ma_ex_wr    (ex_wr),
    .i_ma_ex_addr  (ex_addr),
    .i_ma_ex_wdata (ex_wdata),
    .o_ma_ex_gnt   (ex_gnt),
    .o_ma_ex_vld   (ex_vld),
    .o_ma_rdata    (rdata),
    .o_ma_busy     (busy),
    .mem           (mem_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align(input int c);
    for (int i = 0; i < 4 && (cyc % 4) != c; i++) next_cycle();
  endtask

  task automatic test_reset;
    rst = 1'b1; fe_req = 1'b0; fe_addr = '0; ex_req = 1'b0; ex_wr = 1'b0;
    ex_addr = '0; ex_wdata = '0; mem_if.sio_rd = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; cyc = 0;
    #2;
    n_run++; if (ctr !== 2'd0) begin n_fail++; $display("FAIL rst_ctr: got %0d want 0", ctr); end
    n_run++; if ({mem_if.cs, mem_if.we, mem_if.oe, busy} !== 4'b0) begin n_fail++;
      $display("FAIL rst_ctl: got cs/we/oe/busy=%b want 0000", {mem_if.cs, mem_if.we, mem_if.oe, busy}); end
    n_run++; if ({fe_gnt, ex_gnt, fe_vld, ex_vld} !== 4'b0) begin n_fail++;
      $display("FAIL rst_gnt_vld: got %b want 0000", {fe_gnt, ex_gnt, fe_vld, ex_vld}); end
    n_run++; if (mem_if.sio !== 4'h0) begin n_fail++; $display("FAIL rst_sio: got %h want 0", mem_if.sio); end
  endtask

  task automatic test_idle;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) begin next_cycle(); #2; end
      n_run++; if (ctr !== ctr_t'(i % 4)) begin n_fail++; $display("FAIL idle_ctr[%0d]: got %0d want %0d", i, ctr, i % 4); end
      n_run++; if ({mem_if.cs, fe_gnt, ex_gnt, busy} !== 4'b0) begin n_fail++;
        $display("FAIL idle_ctl[%0d]: got cs/fg/eg/busy=%b want 0000", i, {mem_if.cs, fe_gnt, ex_gnt, busy}); end
    end
  endtask

  task automatic test_fetch_read;
    logic [15:0] a = 16'h1234;
    slice_t exp_a [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    slice_t rd [4]    = '{4'hF, 4'hE, 4'hE, 4'hB};
    align(1);
    fe_req = 1'b1;
    #2;
    n_run++; if (fe_gnt !== 1'b0) begin n_fail++; $display("FAIL fe_gnt_ctr1: got %b want 0", fe_gnt); end
    next_cycle(); #2;
    n_run++; if (fe_gnt !== 1'b0) begin n_fail++; $display("FAIL fe_gnt_ctr2: got %b want 0", fe_gnt); end
    next_cycle(); #2;
    n_run++; if ({fe_gnt, ex_gnt} !== 2'b10) begin n_fail++; $display("FAIL fe_gnt_ctr3: got fg/eg=%b want 10", {fe_gnt, ex_gnt}); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      fe_req = 1'b0; fe_addr = a[i*4 +: 4];
      #2;
      n_run++; if (mem_if.sio !== exp_a[i]) begin n_fail++; $display("FAIL fe_addr_sio[%0d]: got %h want %h", i, mem_if.sio, exp_a[i]); end
      n_run++; if ({mem_if.cs, mem_if.oe, mem_if.we} !== 3'b110) begin n_fail++;
        $display("FAIL fe_addr_ctl[%0d]: got cs/oe/we=%b want 110", i, {mem_if.cs, mem_if.oe, mem_if.we}); end
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      fe_addr = '0; mem_if.sio_rd = rd[i];
      #2;
      n_run++; if ({fe_vld, ex_vld} !== 2'b10) begin n_fail++; $display("FAIL fe_vld[%0d]: got fv/ev=%b want 10", i, {fe_vld, ex_vld}); end
      n_run++; if (rdata !== rd[i]) begin n_fail++; $display("FAIL fe_rdata[%0d]: got %h want %h", i, rdata, rd[i]); end
      n_run++; if ({mem_if.oe, mem_if.sio} !== 5'b0) begin n_fail++;
        $display("FAIL fe_data_drive[%0d]: got oe=%b sio=%h want 0 0", i, mem_if.oe, mem_if.sio); end
    end
    next_cycle(); mem_if.sio_rd = '0; #2;
    n_run++; if ({mem_if.cs, fe_vld, busy} !== 3'b0) begin n_fail++;
      $display("FAIL fe_end: got cs/fv/busy=%b want 000", {mem_if.cs, fe_vld, busy}); end
  endtask

  task automatic test_ex_store;
    logic [15:0] a = 16'h00A0;
    logic [15:0] d = 16'h5A5A;
    slice_t exp_a [4] = '{4'h0, 4'hA, 4'h0, 4'h0};
    slice_t exp_d [4] = '{4'hA, 4'h5, 4'hA, 4'h5};
    align(0);
    ex_req = 1'b1; ex_wr = 1'b1;
    next_cycle(); next_cycle(); next_cycle(); #2;
    n_run++; if ({fe_gnt, ex_gnt} !== 2'b01) begin n_fail++; $display("FAIL ex_gnt: got fg/eg=%b want 01", {fe_gnt, ex_gnt}); end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ex_req = 1'b0; ex_wr = 1'b0; ex_addr = a[i*4 +: 4]; mem_if.sio_rd = 4'h3;
      #2;
      n_run++; if (mem_if.sio !== exp_a[i]) begin n_fail++; $display("FAIL ex_addr_sio[%0d]: got %h want %h", i, mem_if.sio, exp_a[i]); end
      n_run++; if ({mem_if.we, mem_if.oe} !== 2'b11) begin n_fail++; $display("FAIL ex_addr_weoe[%0d]: got %b want 11", i, {mem_if.we, mem_if.oe}); end
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      ex_addr = '0; ex_wdata = d[i*4 +: 4];
      #2;
      n_run++; if (mem_if.sio !== exp_d[i]) begin n_fail++; $display("FAIL ex_wdata_sio[%0d]: got %h want %h", i, mem_if.sio, exp_d[i]); end
      n_run++; if ({mem_if.we, mem_if.oe} !== 2'b11) begin n_fail++; $display("FAIL ex_data_weoe[%0d]: got %b want 11", i, {mem_if.we, mem_if.oe}); end
      n_run++; if ({ex_vld, fe_vld} !== 2'b00) begin n_fail++; $display("FAIL ex_store_vld[%0d]: got ev/fv=%b want 00", i, {ex_vld, fe_vld}); end
    end
    next_cycle(); ex_wdata = '0; mem_if.sio_rd = '0; #2;
    n_run++; if ({mem_if.cs, mem_if.we, mem_if.oe} !== 3'b0) begin n_fail++;
      $display("FAIL ex_end: got cs/we/oe=%b want 000", {mem_if.cs, mem_if.we, mem_if.oe}); end
  endtask

  task automatic test_req_drop;
    align(0);
    fe_req = 1'b1;
    #2;
    n_run++; if ({fe_gnt, busy} !== 2'b00) begin n_fail++; $display("FAIL drop_ctr0: got fg/busy=%b want 00", {fe_gnt, busy}); end
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      fe_req = 1'b0;
      #2;
      n_run++; if ({fe_gnt, ex_gnt, mem_if.cs, busy} !== 4'b0) begin n_fail++;
        $display("FAIL drop[%0d]: got fg/eg/cs/busy=%b want 0000", i, {fe_gnt, ex_gnt, mem_if.cs, busy}); end
    end
  endtask

  task automatic test_back_to_back;
    logic   e_eg, e_fg, e_cs, e_ev, e_fv, own_ex;
    slice_t e_sio;
    rst = 1'b1; fe_req = 1'b1; ex_req = 1'b1; ex_wr = 1'b0;
    fe_addr = 4'h1; ex_addr = 4'h2; mem_if.sio_rd = 4'h7;
    @(posedge clk);
    #1; rst = 1'b0; cyc = 0;
    for (int c = 0; c < 36; c++) begin
      if (c != 0) next_cycle();
      if (cyc == 35) begin fe_req = 1'b0; ex_req = 1'b0; end
      #2;
      e_eg = (cyc == 3) || (cyc == 19);
      e_fg = (cyc == 11) || (cyc == 27);
      e_cs = (cyc >= 4);
      own_ex = (cyc >= 4) && ((((cyc - 4) / 8) % 2) == 0);
      e_sio = 4'h0; e_ev = 1'b0; e_fv = 1'b0;
      if (cyc >= 4) begin
        if (((cyc - 4) % 8) < 4) e_sio = own_ex ? 4'h2 : 4'h1;
        else begin e_ev = own_ex; e_fv = !own_ex; end
      end
      n_run++; if ({ex_gnt, fe_gnt} !== {e_eg, e_fg}) begin n_fail++;
        $display("FAIL b2b_gnt[%0d]: got eg/fg=%b want %b", cyc, {ex_gnt, fe_gnt}, {e_eg, e_fg}); end
      n_run++; if (mem_if.cs !== e_cs) begin n_fail++; $display("FAIL b2b_cs[%0d]: got %b want %b", cyc, mem_if.cs, e_cs); end
      n_run++; if (mem_if.sio !== e_sio) begin n_fail++; $display("FAIL b2b_sio[%0d]: got %h want %h", cyc, mem_if.sio, e_sio); end
      n_run++; if ({ex_vld, fe_vld} !== {e_ev, e_fv}) begin n_fail++;
        $display("FAIL b2b_vld[%0d]: got ev/fv=%b want %b", cyc, {ex_vld, fe_vld}, {e_ev, e_fv}); end
    end
    next_cycle(); mem_if.sio_rd = '0; fe_addr = '0; ex_addr = '0; #2;
    n_run++; if ({mem_if.cs, busy} !== 2'b00) begin n_fail++; $display("FAIL b2b_end: got cs/busy=%b want 00", {mem_if.cs, busy}); end
  endtask

  task automatic test_reset_mid;
    align(0);
    ex_req = 1'b1; ex_wr = 1'b0;
    next_cycle(); next_cycle(); next_cycle(); #2;
    n_run++; if ({ex_gnt, fe_gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_ex_gnt: got eg/fg=%b want 10", {ex_gnt, fe_gnt}); end
    for (int i = 0; i < 4; i++) begin next_cycle(); ex_req = 1'b0; end
    next_cycle(); mem_if.sio_rd = 4'h9; #2;
    n_run++; if (ex_vld !== 1'b1) begin n_fail++; $display("FAIL mid_ex_vld: got %b want 1", ex_vld); end
    next_cycle(); rst = 1'b1; #2;
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_edge: got %b want 1", busy); end
    next_cycle(); rst = 1'b0; cyc = 0; mem_if.sio_rd = '0; #2;
    n_run++; if (ctr !== 2'd0) begin n_fail++; $display("FAIL mid_ctr: got %0d want 0", ctr); end
    n_run++; if ({mem_if.cs, mem_if.we, mem_if.oe, busy, mem_if.sio} !== 8'b0) begin n_fail++;
      $display("FAIL mid_ctl: got cs/we/oe/busy/sio=%b want 0", {mem_if.cs, mem_if.we, mem_if.oe, busy, mem_if.sio}); end
    n_run++; if ({fe_gnt, ex_gnt, fe_vld, ex_vld} !== 4'b0) begin n_fail++;
      $display("FAIL mid_gnt_vld: got %b want 0000", {fe_gnt, ex_gnt, fe_vld, ex_vld}); end
    fe_req = 1'b1; ex_req = 1'b1;
    next_cycle(); next_cycle(); next_cycle(); #2;
    n_run++; if ({ex_gnt, fe_gnt} !== 2'b10) begin n_fail++; $display("FAIL mid_conflict: got eg/fg=%b want 10", {ex_gnt, fe_gnt}); end
    fe_req = 1'b0; ex_req = 1'b0;
    repeat (9) next_cycle();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_fetch_read();
    test_ex_store();
    test_req_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
